// File: rtl/arp_pkg.sv
// arp_pkg: FSM states, ARP opcodes and broadcast MAC shared by the ARP controller files
package arp_pkg;
   typedef enum logic [2:0] {
      IDLE,
      TX_REQ,
      TX_RPLY,
      WAIT_TXDONE,
      WAIT_REPLY
   } arp_state_t;
   localparam logic        ARP_OP_REQ   = 1'b0;
   localparam logic        ARP_OP_REPLY = 1'b1;
   localparam logic [47:0] BCAST_MAC    = 48'hff_ff_ff_ff_ff_ff;
endpackage

// File: rtl/arp_retry_timer.sv
// arp_retry_timer: saturating 32-bit cycle counter with synchronous load-to-zero and terminal-count flag
module arp_retry_timer #(
   parameter logic [31:0] TERM = 32'd1000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc
);
   logic [31:0] r_cnt;
   // count while enabled and hold at all-ones rather than wrapping
   always_ff @(posedge clk) begin
      if (reset || i_load) r_cnt <= '0;
      else if (i_en && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
   end
   // stays high once reached, so a check delayed by a frame in flight still sees expiry
   assign o_tc = r_cnt >= TERM - 32'd1;
endmodule

// File: rtl/arp_ctrl.sv
// arp_ctrl: ARP reply/request controller with single-entry cache; optional aging via ARP_CACHE_AGING_EN
module arp_ctrl import arp_pkg::*; #(
   parameter logic [47:0] DES_MAC          = BCAST_MAC,
   parameter logic [31:0] RETRY_CYCLES     = 32'd125_000_000,
   parameter int unsigned MAX_RETRY        = 3,
   parameter logic [31:0] CACHE_TTL_CYCLES = 32'd3_750_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arp_rx_done,
   input  logic        arp_rx_type,
   input  logic [47:0] src_mac,
   input  logic [31:0] src_ip,
   output logic        arp_tx_en,
   output logic        arp_tx_type,
   output logic [47:0] des_mac,
   output logic [31:0] des_ip,
   input  logic        tx_done,
   input  logic        resolve_req,
   input  logic [31:0] resolve_ip,
   output logic        resolve_busy,
   output logic        mac_valid,
   output logic [47:0] resolved_mac,
   output logic [31:0] resolved_ip,
   output logic        resolve_fail
);
   arp_state_t  r_state;
   logic        r_tx_en, r_tx_type, r_busy, r_valid, r_fail, r_pend, r_res_pend;
   logic [47:0] r_des_mac, r_rmac, r_buf_mac;
   logic [31:0] r_des_ip, r_rip, r_buf_ip;
   logic [7:0]  r_retry;
   logic        w_rx_req, w_pend, w_miss, w_learn, w_done, w_can_retry, w_late_req;
   logic        w_tmr_load, w_tmr_tc, w_age_tc;
   assign w_rx_req    = arp_rx_done && arp_rx_type == ARP_OP_REQ;
   assign w_pend      = r_pend || w_rx_req;
   assign w_miss      = r_state == IDLE && resolve_req && !(r_valid && resolve_ip == r_rip);
   assign w_learn     = arp_rx_done && src_ip == r_rip && (r_busy || r_valid);
   assign w_done      = w_learn || r_valid;
   assign w_can_retry = 32'(r_retry) < MAX_RETRY;
   assign w_late_req  = r_state == WAIT_TXDONE && tx_done && r_res_pend;
   assign w_tmr_load  = w_miss || w_late_req ||
                        (r_state == WAIT_REPLY && !w_done && !w_pend && w_tmr_tc && w_can_retry);
   arp_retry_timer #(.TERM(RETRY_CYCLES)) u_retry (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_tmr_load),
      .i_en   (r_busy),
      .o_tc   (w_tmr_tc)
   );
`ifdef ARP_CACHE_AGING_EN
   arp_retry_timer #(.TERM(CACHE_TTL_CYCLES)) u_age (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_learn || !r_valid),
      .i_en   (r_valid),
      .o_tc   (w_age_tc)
   );
`else
   logic w_unused_ttl;
   assign w_unused_ttl = ^CACHE_TTL_CYCLES;
   assign w_age_tc     = 1'b0;
`endif
   // protocol FSM with cache, reply buffer and registered transmit outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tx_en    <= 1'b0;
         r_tx_type  <= 1'b0;
         r_des_mac  <= '0;
         r_des_ip   <= '0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_rmac     <= '0;
         r_rip      <= '0;
         r_fail     <= 1'b0;
         r_pend     <= 1'b0;
         r_res_pend <= 1'b0;
         r_buf_mac  <= '0;
         r_buf_ip   <= '0;
         r_retry    <= '0;
      end else begin
         r_tx_en <= 1'b0;
         r_fail  <= 1'b0;
         if (w_age_tc) r_valid <= 1'b0;
         if (w_learn) begin
            r_rmac  <= src_mac;
            r_valid <= 1'b1;
         end
         unique case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_rip   <= resolve_ip;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b1;
                  r_retry <= '0;
               end
               // a reply goes first; a simultaneous miss is owed a request after it
               if (w_pend) begin
                  r_res_pend <= w_miss;
                  r_state    <= TX_RPLY;
               end else if (w_miss) r_state <= TX_REQ;
            end
            TX_REQ: begin
               r_tx_en   <= 1'b1;
               r_tx_type <= ARP_OP_REQ;
               r_des_mac <= DES_MAC;
               r_des_ip  <= r_rip;
               r_state   <= WAIT_TXDONE;
            end
            TX_RPLY: begin
               r_tx_en   <= 1'b1;
               r_tx_type <= ARP_OP_REPLY;
               r_des_mac <= r_buf_mac;
               r_des_ip  <= r_buf_ip;
               r_pend    <= 1'b0;
               r_state   <= WAIT_TXDONE;
            end
            WAIT_TXDONE: begin
               if (tx_done) begin
                  r_res_pend <= 1'b0;
                  r_state    <= r_res_pend ? TX_REQ : r_busy ? WAIT_REPLY : IDLE;
               end
            end
            WAIT_REPLY: begin
               if (w_done) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_pend) r_state <= TX_RPLY;
               else if (w_tmr_tc) begin
                  if (w_can_retry) begin
                     r_retry <= r_retry + 8'd1;
                     r_state <= TX_REQ;
                  end else begin
                     r_fail  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         // capture last, so a new request wins over the clear in TX_RPLY
         if (w_rx_req) begin
            r_buf_mac <= src_mac;
            r_buf_ip  <= src_ip;
            r_pend    <= 1'b1;
         end
      end
   end
   assign arp_tx_en    = r_tx_en;
   assign arp_tx_type  = r_tx_type;
   assign des_mac      = r_des_mac;
   assign des_ip       = r_des_ip;
   assign resolve_busy = r_busy;
   assign mac_valid    = r_valid;
   assign resolved_mac = r_rmac;
   assign resolved_ip  = r_rip;
   assign resolve_fail = r_fail;
endmodule
